seq_shifter: RTL and testbench

SEQ_SHIFTER -- requirements
Module: seq_shifter

---
 rtl/seq_shifter.sv | 90 +++++++++
 tb/tb_seq_shifter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// seq_shifter: iterative rotate/shift unit that moves up to STEP bits per cycle with valid/ready handshakes.
// Define SEQ_SHIFTER_FAST_EN to apply the whole shift in the accept cycle with a single-cycle barrel shifter.
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int STEP  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 op,
    input  logic [$clog2(WIDTH)-1:0]   amt,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           data_out
);
    localparam int AMT_W = $clog2(WIDTH);
    localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [AMT_W-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [1:0]        op_q, op_d;
    logic              sign_q, sign_d;
    logic [AMT_W-1:0]  k;

    // SRA flips negative operands, shifts logically, then flips back so the fill is the captured sign.
    function automatic logic [WIDTH-1:0] shf(input logic [1:0] o, input logic [WIDTH-1:0] v,
                                             input logic [AMT_W-1:0] n, input logic s);
        return o == 2'd0 ? (v << n) | (v >> (WIDTH - int'(n))) :
               o == 2'd1 ? v << n :
               o == 2'd2 ? ((v ^ {WIDTH{s}}) >> n) ^ {WIDTH{s}} :
                           v >> n;
    endfunction

    assign k = rem_q < STEP_A ? rem_q : STEP_A;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        work_d  = work_q;
        op_d    = op_q;
        sign_d  = sign_q;
        case (state_q)
            IDLE: if (in_valid) begin
                op_d   = op;
                sign_d = data_in[WIDTH-1];
`ifdef SEQ_SHIFTER_FAST_EN
                work_d  = shf(op, data_in, amt, data_in[WIDTH-1]);
                rem_d   = '0;
                state_d = DONE;
`else
                work_d  = data_in;
                rem_d   = amt;
                state_d = amt == '0 ? DONE : SHIFT;
`endif
            end
            SHIFT: begin
                work_d  = shf(op_q, work_q, k, sign_q);
                rem_d   = rem_q - k;
                state_d = rem_q == k ? DONE : SHIFT;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            work_q  <= '0;
            op_q    <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            work_q  <= work_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign data_out  = work_q;
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: table-driven vectors through a scoreboard queue, plus hold, reset-abort and random sequences.
module tb_seq_shifter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [3:0]  amt;
    logic [15:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] data_out;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  amt;
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[13];

    seq_shifter #(.WIDTH(16), .STEP(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .amt(amt),
        .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // One bit per iteration, independent of how the DUT groups its steps.
    function automatic logic [15:0] ref_shift(input logic [1:0] o, input logic [3:0] a, input logic [15:0] d);
        logic [15:0] r = d;
        for (int i = 0; i < int'(a); i++)
            r = o == 2'd0 ? {r[14:0], r[15]} : o == 2'd1 ? {r[14:0], 1'b0} :
                o == 2'd2 ? {d[15], r[15:1]} : {1'b0, r[15:1]};
        return r;
    endfunction

    function automatic int exp_lat(input logic [3:0] a);
`ifdef SEQ_SHIFTER_FAST_EN
        return 0;
`else
        return (int'(a) + 1) / 2;
`endif
    endfunction

    // Called with the DUT idle and out_ready=1, one time unit after a rising edge.
    task automatic run(input logic [1:0] o, input logic [3:0] a, input logic [15:0] d, input logic [15:0] e);
        int cyc = 0;
        op = o; amt = a; data_in = d; in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        in_valid = 1'b0; op = ~o; amt = ~a; data_in = ~d;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        check("latency", cyc, exp_lat(a));
        check("busy_in_ready", in_ready, 1'b0);
        check("data_out", data_out, exp_q.pop_front());
        @(posedge clk); #1;
        check("back_to_idle", {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        vecs[0]  = '{2'd0, 4'd3,  16'h8001, 16'h000C};
        vecs[1]  = '{2'd2, 4'd15, 16'h8000, 16'hFFFF};
        vecs[2]  = '{2'd3, 4'd15, 16'h8000, 16'h0001};
        vecs[3]  = '{2'd1, 4'd0,  16'h0001, 16'h0001};
        vecs[4]  = '{2'd0, 4'd15, 16'h0001, 16'h8000};
        vecs[5]  = '{2'd1, 4'd1,  16'hC003, 16'h8006};
        vecs[6]  = '{2'd2, 4'd4,  16'h7F00, 16'h07F0};
        vecs[7]  = '{2'd2, 4'd5,  16'hF0F0, 16'hFF87};
        vecs[8]  = '{2'd3, 4'd7,  16'hABCD, 16'h0157};
        vecs[9]  = '{2'd0, 4'd8,  16'h12AB, 16'hAB12};
        vecs[10] = '{2'd1, 4'd7,  16'h00FF, 16'h7F80};
        vecs[11] = '{2'd3, 4'd0,  16'hBEEF, 16'hBEEF};
        vecs[12] = '{2'd2, 4'd1,  16'h8001, 16'hC000};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; amt = '0; data_in = '0;
        #1;
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_data_out", data_out, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run(vecs[i].op, vecs[i].amt, vecs[i].din, vecs[i].exp);

        // Result held while the consumer stalls; requests during DONE are ignored.
        out_ready = 1'b0;
        op = 2'd1; amt = 4'd0; data_in = 16'h1234; in_valid = 1'b1;
        @(posedge clk); exp_q.push_back(16'h1234); #1;
        in_valid = 1'b0;
        check("hold_valid", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0]; op = 2'd0; amt = 4'd5; data_in = 16'hFFFF;
            @(posedge clk); #1;
            check("hold_data", data_out, exp_q[0]);
            check("hold_flags", {in_ready, out_valid}, 2'b01);
        end
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        void'(exp_q.pop_front());
        check("release_idle", {in_ready, out_valid}, 2'b10);
        in_valid = 1'b0;

        // Reset in the middle of a long shift throws the result away.
        op = 2'd1; amt = 4'd9; data_in = 16'h0001; in_valid = 1'b1;
        @(posedge clk); exp_q.push_back(16'h0200); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {in_ready, out_valid, data_out}, {2'b10, 16'h0000});
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("abort_no_stale", out_valid, 1'b0);
        end
        run(2'd1, 4'd9, 16'h0001, 16'h0200);

        for (int i = 0; i < 8; i++) begin
            logic [1:0]  o = 2'($urandom_range(0, 3));
            logic [3:0]  a = 4'($urandom_range(0, 15));
            logic [15:0] d = 16'($urandom);
            run(o, a, d, ref_shift(o, a, d));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
